// File: rtl/jpeg_rle_symbolizer.sv
// JPEG run-length symbolizer: turns one zigzag-ordered, DC-differenced block of
// 64 coefficients into (run, size, amplitude) symbols, with ZRL and EOB
// generation, at most one symbol per cycle.
module jpeg_rle_symbolizer #(
  parameter int unsigned COEF_WIDTH = 10,
  parameter int unsigned NUM_COEF   = 64
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           block_valid,
  output logic                           block_ready,
  input  logic [COEF_WIDTH*NUM_COEF-1:0] block_data,
  output logic                           sym_valid,
  input  logic                           sym_ready,
  output logic                           sym_is_dc,
  output logic [3:0]                     sym_run,
  output logic [3:0]                     sym_size,
  output logic [COEF_WIDTH-1:0]          sym_amp,
  output logic                           sym_last,
  output logic                           busy
);

  localparam int unsigned IdxW = $clog2(NUM_COEF);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_COEF - 1);

  // StDc: DC symbol sits in the output register; scanning of AC coefficients
  // starts as soon as it drains. StDrain: final symbol waits for its handshake.
  typedef enum logic [2:0] {
    StIdle,
    StDc,
    StAc,
    StEob,
    StDrain
  } state_e;

  state_e                          state_q, state_d;
  logic [COEF_WIDTH*NUM_COEF-1:0]  shadow_q, shadow_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [5:0]                      run_q, run_d;

  logic                  sym_valid_q, sym_valid_d;
  logic                  sym_is_dc_q, sym_is_dc_d;
  logic [3:0]            sym_run_q, sym_run_d;
  logic [3:0]            sym_size_q, sym_size_d;
  logic [COEF_WIDTH-1:0] sym_amp_q, sym_amp_d;
  logic                  sym_last_q, sym_last_d;

  // Magnitude category: bit length of |v|.
  function automatic logic [3:0] coef_size(input logic [COEF_WIDTH-1:0] v);
    logic [COEF_WIDTH:0] ext;
    logic [COEF_WIDTH:0] mag;
    logic [3:0]          size;
    ext  = {v[COEF_WIDTH-1], v};
    mag  = ext[COEF_WIDTH] ? (~ext + 1'b1) : ext;
    size = 4'd0;
    for (int i = 0; i < int'(COEF_WIDTH) + 1; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    return size;
  endfunction

  // Amplitude bits: v when positive, else low `size` bits of (v - 1).
  function automatic logic [COEF_WIDTH-1:0] coef_amp(input logic [COEF_WIDTH-1:0] v,
                                                     input logic [3:0]            size);
    logic [COEF_WIDTH:0] ext;
    logic [COEF_WIDTH:0] dec;
    logic [COEF_WIDTH:0] mask;
    ext  = {v[COEF_WIDTH-1], v};
    dec  = ext - 1'b1;
    mask = {(COEF_WIDTH + 1){1'b1}} >> (int'(COEF_WIDTH) + 1 - int'(size));
    if (!v[COEF_WIDTH-1] && (v != '0)) return v;
    return dec[COEF_WIDTH-1:0] & mask[COEF_WIDTH-1:0];
  endfunction

  logic [COEF_WIDTH-1:0] dc_coef;
  logic [COEF_WIDTH-1:0] cur_coef;
  logic [3:0]            dc_size;
  logic [3:0]            cur_size;
  logic                  sym_free;

  logic                  ld_en;
  logic                  clr_en;
  logic                  ld_is_dc;
  logic [3:0]            ld_run;
  logic [3:0]            ld_size;
  logic [COEF_WIDTH-1:0] ld_amp;
  logic                  ld_last;

  assign dc_coef  = block_data[COEF_WIDTH-1:0];
  assign cur_coef = shadow_q[int'(idx_q)*int'(COEF_WIDTH) +: COEF_WIDTH];
  assign dc_size  = coef_size(dc_coef);
  assign cur_size = coef_size(cur_coef);
  // Output register may take a new symbol when empty or being consumed now.
  assign sym_free = !sym_valid_q || sym_ready;

  // Next-state, scan bookkeeping and symbol register load/clear decisions.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    run_d    = run_q;
    ld_en    = 1'b0;
    clr_en   = 1'b0;
    ld_is_dc = 1'b0;
    ld_run   = 4'd0;
    ld_size  = 4'd0;
    ld_amp   = '0;
    ld_last  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (block_valid) begin
          shadow_d = block_data;
          ld_en    = 1'b1;
          ld_is_dc = 1'b1;
          ld_size  = dc_size;
          ld_amp   = coef_amp(dc_coef, dc_size);
          idx_d    = IdxW'(1);
          run_d    = 6'd0;
          state_d  = StDc;
        end
      end
      StDc, StAc: begin
        if (sym_free) begin
          if (cur_coef == '0) begin
            clr_en  = 1'b1;
            run_d   = run_q + 6'd1;
            idx_d   = idx_q + IdxW'(1);
            state_d = (idx_q == LastIdx) ? StEob : StAc;
          end else if (run_q >= 6'd16) begin
            ld_en   = 1'b1;
            ld_run  = 4'd15;
            run_d   = run_q - 6'd16;
            state_d = StAc;
          end else begin
            ld_en   = 1'b1;
            ld_run  = run_q[3:0];
            ld_size = cur_size;
            ld_amp  = coef_amp(cur_coef, cur_size);
            ld_last = (idx_q == LastIdx);
            run_d   = 6'd0;
            idx_d   = idx_q + IdxW'(1);
            state_d = (idx_q == LastIdx) ? StDrain : StAc;
          end
        end
      end
      StEob: begin
        if (sym_free) begin
          ld_en   = 1'b1;
          ld_last = 1'b1;
          run_d   = 6'd0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (sym_ready) begin
          clr_en  = 1'b1;
          idx_d   = '0;
          run_d   = 6'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Symbol output register: load a new symbol, clear after consumption, else hold.
  always_comb begin
    sym_valid_d = sym_valid_q;
    sym_is_dc_d = sym_is_dc_q;
    sym_run_d   = sym_run_q;
    sym_size_d  = sym_size_q;
    sym_amp_d   = sym_amp_q;
    sym_last_d  = sym_last_q;
    if (ld_en) begin
      sym_valid_d = 1'b1;
      sym_is_dc_d = ld_is_dc;
      sym_run_d   = ld_run;
      sym_size_d  = ld_size;
      sym_amp_d   = ld_amp;
      sym_last_d  = ld_last;
    end else if (clr_en) begin
      sym_valid_d = 1'b0;
      sym_is_dc_d = 1'b0;
      sym_run_d   = 4'd0;
      sym_size_d  = 4'd0;
      sym_amp_d   = '0;
      sym_last_d  = 1'b0;
    end
  end

  // State and datapath registers; reset drops any block in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      idx_q       <= '0;
      run_q       <= 6'd0;
      sym_valid_q <= 1'b0;
      sym_is_dc_q <= 1'b0;
      sym_run_q   <= 4'd0;
      sym_size_q  <= 4'd0;
      sym_amp_q   <= '0;
      sym_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      sym_valid_q <= sym_valid_d;
      sym_is_dc_q <= sym_is_dc_d;
      sym_run_q   <= sym_run_d;
      sym_size_q  <= sym_size_d;
      sym_amp_q   <= sym_amp_d;
      sym_last_q  <= sym_last_d;
    end
  end

  assign block_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign sym_valid   = sym_valid_q;
  assign sym_is_dc   = sym_is_dc_q;
  assign sym_run     = sym_run_q;
  assign sym_size    = sym_size_q;
  assign sym_amp     = sym_amp_q;
  assign sym_last    = sym_last_q;

endmodule

// File: tb/tb_jpeg_rle_symbolizer.sv
// Self-checking bench for jpeg_rle_symbolizer: directed size/amplitude table,
// hand-written corner sequences and random blocks under backpressure, all
// checked through a symbol scoreboard.
module tb_jpeg_rle_symbolizer;

  typedef struct packed {
    logic       is_dc;
    logic [3:0] run;
    logic [3:0] size;
    logic [9:0] amp;
    logic       last;
  } sym_t;

  typedef struct {
    int v;
    int size;
    int amp;
  } vec_t;

  logic         clock;
  logic         reset_n;
  logic         block_valid;
  logic         block_ready;
  logic [639:0] block_data;
  logic         sym_valid;
  logic         sym_ready;
  logic         sym_is_dc;
  logic [3:0]   sym_run;
  logic [3:0]   sym_size;
  logic [9:0]   sym_amp;
  logic         sym_last;
  logic         busy;

  int   checks;
  int   failures;
  int   sym_count;
  bit   bp_en;
  sym_t sb[$];

  jpeg_rle_symbolizer #(
    .COEF_WIDTH(10),
    .NUM_COEF  (64)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .block_data (block_data),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_is_dc  (sym_is_dc),
    .sym_run    (sym_run),
    .sym_size   (sym_size),
    .sym_amp    (sym_amp),
    .sym_last   (sym_last),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1);
  end

  // Downstream ready: random when backpressure enabled, else always ready.
  always @(posedge clock) begin
    #1;
    sym_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stall stability and scoreboard compare on each handshake.
  sym_t prev_sym;
  bit   prev_stall;
  always @(negedge clock) begin
    sym_t cur;
    sym_t exp;
    cur = {sym_is_dc, sym_run, sym_size, sym_amp, sym_last};
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!sym_valid || cur !== prev_sym) begin
          failures++;
          $display("FAIL stall_hold: got valid=%0b sym=%h, required valid=1 sym=%h",
                   sym_valid, cur, prev_sym);
        end
      end
      if (sym_valid && sym_ready) begin
        sym_count++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_sym: got dc=%0b run=%0d size=%0d amp=%0d last=%0b, required none",
                   cur.is_dc, cur.run, cur.size, cur.amp, cur.last);
        end else begin
          exp = sb.pop_front();
          if (cur !== exp) begin
            failures++;
            $display("FAIL symbol: got dc=%0b run=%0d size=%0d amp=%0d last=%0b, required dc=%0b run=%0d size=%0d amp=%0d last=%0b",
                     cur.is_dc, cur.run, cur.size, cur.amp, cur.last,
                     exp.is_dc, exp.run, exp.size, exp.amp, exp.last);
          end
        end
      end
      prev_stall = sym_valid && !sym_ready;
      prev_sym   = cur;
    end
  end

  function automatic int ref_size(input int v);
    int m;
    int n;
    m = (v < 0) ? -v : v;
    n = 0;
    while (m > 0) begin
      n++;
      m = m >> 1;
    end
    return n;
  endfunction

  function automatic int ref_amp(input int v);
    if (v > 0) return v;
    return v + (1 << ref_size(v)) - 1;
  endfunction

  function automatic int coef_of(input logic [639:0] d, input int k);
    logic signed [9:0] c;
    c = d[10*k +: 10];
    return int'(c);
  endfunction

  function automatic logic [639:0] set_coef(input logic [639:0] d, input int k, input int v);
    logic [639:0] r;
    r = d;
    r[10*k +: 10] = 10'(v);
    return r;
  endfunction

  task automatic push_sym(input bit dc, input int run, input int size, input int amp,
                          input bit last);
    sym_t s;
    s.is_dc = dc;
    s.run   = 4'(run);
    s.size  = 4'(size);
    s.amp   = 10'(amp);
    s.last  = last;
    sb.push_back(s);
  endtask

  // Reference symbol stream for one block.
  task automatic push_model(input logic [639:0] d);
    int run;
    int v;
    int last_nz;
    v = coef_of(d, 0);
    push_sym(1'b1, 0, ref_size(v), ref_amp(v), 1'b0);
    last_nz = 0;
    for (int k = 1; k < 64; k++) if (coef_of(d, k) != 0) last_nz = k;
    run = 0;
    for (int k = 1; k < 64; k++) begin
      v = coef_of(d, k);
      if (v == 0) begin
        run++;
      end else begin
        while (run >= 16) begin
          push_sym(1'b0, 15, 0, 0, 1'b0);
          run -= 16;
        end
        push_sym(1'b0, run, ref_size(v), ref_amp(v), k == 63);
        run = 0;
      end
    end
    if (last_nz != 63) push_sym(1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic send_block(input logic [639:0] d);
    int n;
    n = 0;
    while (1) begin
      @(posedge clock);
      #1;
      if (block_ready) break;
      n++;
      if (n > 5000) begin
        checks++;
        failures++;
        $display("FAIL block_ready_wait: got block_ready=0, required 1 within 5000 cycles");
        return;
      end
    end
    block_valid = 1'b1;
    block_data  = d;
    @(posedge clock);
    #1;
    block_valid = 1'b0;
    block_data  = {20{$urandom()}};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 || !block_ready) begin
      @(negedge clock);
      n++;
      if (n > 5000) begin
        checks++;
        failures++;
        $display("FAIL drain_wait: got %0d symbols outstanding, required 0 within 5000 cycles",
                 sb.size());
        return;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [22:0] got;
    got = {block_ready, sym_valid, sym_is_dc, sym_run, sym_size, sym_amp, sym_last, busy};
    checks++;
    if (got !== {1'b1, 22'd0}) begin
      failures++;
      $display("FAIL %s: got outputs=%h, required %h", name, got, {1'b1, 22'd0});
    end
  endtask

  vec_t         vecs[17];
  logic [639:0] blk;
  int           c0;
  int           n;

  initial begin
    vecs = '{
      '{0, 0, 0},     '{1, 1, 1},     '{-1, 1, 0},    '{2, 2, 2},
      '{-2, 2, 1},    '{3, 2, 3},     '{-3, 2, 0},    '{4, 3, 4},
      '{-4, 3, 3},    '{7, 3, 7},     '{-8, 4, 7},    '{255, 8, 255},
      '{-256, 9, 255}, '{256, 9, 256}, '{-511, 9, 0},  '{511, 9, 511},
      '{-512, 10, 511}
    };
    checks      = 0;
    failures    = 0;
    sym_count   = 0;
    bp_en       = 1'b0;
    prev_stall  = 1'b0;
    block_valid = 1'b0;
    block_data  = '0;
    sym_ready   = 1'b1;
    reset_n     = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    #10;
    reset_n = 1'b1;

    // All-zero block; block_ready returns the cycle after the EOB handshake.
    push_sym(1'b1, 0, 0, 0, 1'b0);
    push_sym(1'b0, 0, 0, 0, 1'b1);
    send_block('0);
    n = 0;
    while (!(sym_valid && sym_ready && sym_last) && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!(sym_valid && sym_last) || block_ready !== 1'b0) begin
      failures++;
      $display("FAIL eob_ready_low: got last=%0b block_ready=%0b, required last=1 block_ready=0",
               sym_last, block_ready);
    end
    @(negedge clock);
    checks++;
    if (block_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL eob_ready_back: got block_ready=%0b busy=%0b, required 1 0",
               block_ready, busy);
    end
    wait_drain();

    // Size/amplitude table, each value carried as the DC coefficient.
    for (int i = 0; i < 17; i++) begin
      push_sym(1'b1, 0, vecs[i].size, vecs[i].amp, 1'b0);
      push_sym(1'b0, 0, 0, 0, 1'b1);
      send_block(set_coef('0, 0, vecs[i].v));
    end
    wait_drain();

    // DC=5, coef1=-3.
    push_sym(1'b1, 0, 3, 5, 1'b0);
    push_sym(1'b0, 0, 2, 0, 1'b0);
    push_sym(1'b0, 0, 0, 0, 1'b1);
    send_block(set_coef(set_coef('0, 0, 5), 1, -3));
    wait_drain();

    // Only coef63=1: three ZRLs then a last symbol, no EOB.
    push_sym(1'b1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) push_sym(1'b0, 15, 0, 0, 1'b0);
    push_sym(1'b0, 14, 1, 1, 1'b1);
    send_block(set_coef('0, 63, 1));
    wait_drain();

    // Extremes.
    push_sym(1'b1, 0, 0, 0, 1'b0);
    push_sym(1'b0, 0, 10, 511, 1'b0);
    push_sym(1'b0, 0, 9, 511, 1'b0);
    push_sym(1'b0, 0, 1, 0, 1'b0);
    push_sym(1'b0, 0, 0, 0, 1'b1);
    send_block(set_coef(set_coef(set_coef('0, 1, -512), 2, 511), 3, -1));
    wait_drain();

    // Random sparse blocks under ~50% backpressure.
    bp_en = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      blk = '0;
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 15) == 0) blk[10*k +: 10] = 10'($urandom_range(0, 1023));
      end
      push_model(blk);
      send_block(blk);
    end
    wait_drain();
    bp_en = 1'b0;

    // Reset in the middle of AC scanning.
    blk = '0;
    for (int k = 0; k < 10; k++) blk = set_coef(blk, k, k + 1);
    push_model(blk);
    c0 = sym_count;
    send_block(blk);
    n = 0;
    while (sym_count < c0 + 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_block_reset");
    sb.delete();
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    c0 = sym_count;
    push_sym(1'b1, 0, 0, 0, 1'b0);
    push_sym(1'b0, 0, 0, 0, 1'b1);
    send_block('0);
    wait_drain();
    repeat (5) @(negedge clock);
    checks++;
    if (sym_count - c0 != 2) begin
      failures++;
      $display("FAIL post_reset_count: got %0d symbols, required 2", sym_count - c0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
